bus_test_scheduler: RTL and testbench

BUS_TEST_SCHEDULER -- requirements
Module: bus_test_scheduler

---
 rtl/bus_test_scheduler_pkg.sv | 35 +++
 rtl/bus_test_scheduler_if.sv | 35 +++
 rtl/bus_test_scheduler_cycle_counter.sv | 32 +++
 rtl/bus_test_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_bus_test_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_test_scheduler_pkg.sv
// mopshub_sched_pkg: shared types and widths for the CAN bus test scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - BUS_W / MASK_W / CNT_W : bus index, bus mask and cycle counter widths
//   - bus_enabled() : mask lookup that treats indices outside the mask as disabled
package mopshub_sched_pkg;

   localparam int BUS_W  = 5;
   localparam int MASK_W = 16;
   localparam int CNT_W  = 16;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_TRIM = 4'd1,
      ST_FIND = 4'd2,
      ST_RX   = 4'd3,
      ST_ENDW = 4'd4,
      ST_GAP  = 4'd5,
      ST_TX   = 4'd6,
      ST_NEXT = 4'd7,
      ST_DONE = 4'd8
   } sched_state_t;

   // Index 16..31 has no mask bit, so such a bus is never enabled.
   function automatic logic bus_enabled(input logic [MASK_W-1:0] mask,
                                        input logic [BUS_W-1:0]  idx);
      logic en;
      if (idx[4] == 1'b0) begin
         en = mask[idx[3:0]];
      end else begin
         en = 1'b0;
      end
      return en;
   endfunction

endpackage

// File: rtl/bus_test_scheduler_if.sv
// bus_test_scheduler_if: control/status bundle of the bus test scheduler.
//   slave  modport : scheduler side (start, end_power_init, bus_mask, rx_done,
//                    tx_done in; trim/test/status outputs out)
//   master modport : controller side, directions mirrored
interface bus_test_scheduler_if;
   import mopshub_sched_pkg::*;

   logic              start;
   logic              end_power_init;
   logic [MASK_W-1:0] bus_mask;
   logic              rx_done;
   logic              tx_done;
   logic              osc_trim_en;
   logic              test_rx;
   logic              test_tx;
   logic              endwait_all;
   logic [BUS_W-1:0]  bus_sel;
   logic              busy;
   logic              scan_done;
   logic              err_timeout;
   logic [BUS_W-1:0]  err_bus;

   modport slave (
      input  start, end_power_init, bus_mask, rx_done, tx_done,
      output osc_trim_en, test_rx, test_tx, endwait_all, bus_sel, busy,
             scan_done, err_timeout, err_bus
   );

   modport master (
      output start, end_power_init, bus_mask, rx_done, tx_done,
      input  osc_trim_en, test_rx, test_tx, endwait_all, bus_sel, busy,
             scan_done, err_timeout, err_bus
   );

endinterface

// File: rtl/bus_test_scheduler_cycle_counter.sv
// sched_cycle_counter: free-running up counter with synchronous clear and a
// terminal-count flag, shared by the GAP wait and the phase timeout.
//   clk_40_m : clock          rst   : synchronous active-low reset
//   clear    : count <= 0     limit : terminal value (tc when count == limit-1)
//   tc       : terminal-count flag, valid in the cycle that completes 'limit' cycles
module sched_cycle_counter
   import mopshub_sched_pkg::*;
(
   input  logic             clk_40_m,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] count_r;

   // Count cycles since the last clear.
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + 16'd1;
      end
   end

   // Counting from 0, the limit-th cycle of a phase sees count == limit-1.
   assign tc = (count_r == (limit - 16'd1));

endmodule

// File: rtl/bus_test_scheduler.sv
// bus_test_scheduler: scans CAN buses 0..N_BUSES; for every enabled bus runs an
// RX test, a one-cycle endwait_all, a GAP_CYCLES idle gap and a TX test.
//   clk_40_m  : clock (rising edge)
//   rst       : synchronous, active-low reset
//   sched_bus : bus_test_scheduler_if.slave (start/end_power_init/bus_mask/
//               rx_done/tx_done in; osc_trim_en/test_rx/test_tx/endwait_all/
//               bus_sel/busy/scan_done/err_timeout/err_bus out)
// Build option: define SCHED_TIMEOUT_EN to bound each RX/TX phase to
// TIMEOUT_CYCLES cycles and report it on err_timeout/err_bus; without it the
// phases wait for their done pulse indefinitely and the error outputs are 0.
module bus_test_scheduler
   import mopshub_sched_pkg::*;
#(
   parameter logic [4:0] N_BUSES        = 5'd15,
   parameter int         GAP_CYCLES     = 120,
   parameter int         TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_40_m,
   input  logic                  rst,
   bus_test_scheduler_if.slave   sched_bus
);

   sched_state_t     state_r;
   logic             osc_trim_en_r;
   logic             test_rx_r;
   logic             test_tx_r;
   logic             endwait_all_r;
   logic [BUS_W-1:0] bus_sel_r;
   logic             busy_r;
   logic             scan_done_r;

   logic             cnt_clear_s;
   logic [CNT_W-1:0] cnt_limit_s;
   logic             cnt_tc_s;
   logic             timeout_s;

   sched_cycle_counter u_cnt (
      .clk_40_m (clk_40_m),
      .rst      (rst),
      .clear    (cnt_clear_s),
      .limit    (cnt_limit_s),
      .tc       (cnt_tc_s)
   );

   // Counter control: it runs only inside GAP/RX/TX; leaving GAP clears it so
   // TX starts from zero.
   always_comb begin
      cnt_clear_s = 1'b1;
      if (state_r == ST_GAP) begin
         cnt_limit_s = CNT_W'(GAP_CYCLES);
      end else begin
         cnt_limit_s = CNT_W'(TIMEOUT_CYCLES);
      end
      case (state_r)
         ST_GAP:  cnt_clear_s = cnt_tc_s;
`ifdef SCHED_TIMEOUT_EN
         ST_RX:   cnt_clear_s = 1'b0;
         ST_TX:   cnt_clear_s = 1'b0;
`endif
         default: cnt_clear_s = 1'b1;
      endcase
   end

   // Phase timeout flag.
   always_comb begin
`ifdef SCHED_TIMEOUT_EN
      if ((state_r == ST_RX) || (state_r == ST_TX)) begin
         timeout_s = cnt_tc_s;
      end else begin
         timeout_s = 1'b0;
      end
`else
      timeout_s = 1'b0;
`endif
   end

   // Scheduler FSM with registered outputs.
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         osc_trim_en_r <= 1'b0;
         test_rx_r     <= 1'b0;
         test_tx_r     <= 1'b0;
         endwait_all_r <= 1'b0;
         bus_sel_r     <= {BUS_W{1'b0}};
         busy_r        <= 1'b0;
         scan_done_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sched_bus.start) begin
                  state_r       <= ST_TRIM;
                  osc_trim_en_r <= 1'b1;
                  busy_r        <= 1'b1;
               end
            end
            ST_TRIM: begin
               if (sched_bus.end_power_init) begin
                  state_r       <= ST_FIND;
                  osc_trim_en_r <= 1'b0;
               end
            end
            // One index per cycle; the mask is read live so later buses
            // follow any mask change.
            ST_FIND: begin
               if (bus_enabled(sched_bus.bus_mask, bus_sel_r)) begin
                  state_r <= ST_RX;
               end else if (bus_sel_r == N_BUSES) begin
                  state_r     <= ST_DONE;
                  scan_done_r <= 1'b1;
               end else begin
                  bus_sel_r <= bus_sel_r + 5'd1;
               end
            end
            // test_rx rises one cycle after entering RX.
            ST_RX: begin
               if (sched_bus.rx_done || timeout_s) begin
                  state_r       <= ST_ENDW;
                  test_rx_r     <= 1'b0;
                  endwait_all_r <= 1'b1;
               end else begin
                  test_rx_r <= 1'b1;
               end
            end
            ST_ENDW: begin
               endwait_all_r <= 1'b0;
               if (GAP_CYCLES == 0) begin
                  state_r   <= ST_TX;
                  test_tx_r <= 1'b1;
               end else begin
                  state_r <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_tc_s) begin
                  state_r   <= ST_TX;
                  test_tx_r <= 1'b1;
               end
            end
            ST_TX: begin
               if (sched_bus.tx_done || timeout_s) begin
                  state_r   <= ST_NEXT;
                  test_tx_r <= 1'b0;
               end
            end
            ST_NEXT: begin
               if (bus_sel_r == N_BUSES) begin
                  state_r     <= ST_DONE;
                  scan_done_r <= 1'b1;
               end else begin
                  state_r   <= ST_FIND;
                  bus_sel_r <= bus_sel_r + 5'd1;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               scan_done_r <= 1'b0;
               bus_sel_r   <= {BUS_W{1'b0}};
               busy_r      <= 1'b0;
            end
            default: begin
               state_r       <= ST_IDLE;
               osc_trim_en_r <= 1'b0;
               test_rx_r     <= 1'b0;
               test_tx_r     <= 1'b0;
               endwait_all_r <= 1'b0;
               bus_sel_r     <= {BUS_W{1'b0}};
               busy_r        <= 1'b0;
               scan_done_r   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SCHED_TIMEOUT_EN
   logic             err_timeout_r;
   logic [BUS_W-1:0] err_bus_r;
   logic             done_in_phase_s;

   // A done pulse in the timeout cycle takes priority over the timeout.
   always_comb begin
      if (state_r == ST_RX) begin
         done_in_phase_s = sched_bus.rx_done;
      end else if (state_r == ST_TX) begin
         done_in_phase_s = sched_bus.tx_done;
      end else begin
         done_in_phase_s = 1'b0;
      end
   end

   // Sticky timeout record, cleared when a new scan is accepted.
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         err_timeout_r <= 1'b0;
         err_bus_r     <= {BUS_W{1'b0}};
      end else if ((state_r == ST_IDLE) && sched_bus.start) begin
         err_timeout_r <= 1'b0;
         err_bus_r     <= {BUS_W{1'b0}};
      end else if (timeout_s && !done_in_phase_s) begin
         err_timeout_r <= 1'b1;
         err_bus_r     <= bus_sel_r;
      end
   end

   assign sched_bus.err_timeout = err_timeout_r;
   assign sched_bus.err_bus     = err_bus_r;
`else
   assign sched_bus.err_timeout = 1'b0;
   assign sched_bus.err_bus     = {BUS_W{1'b0}};
`endif

   assign sched_bus.osc_trim_en = osc_trim_en_r;
   assign sched_bus.test_rx     = test_rx_r;
   assign sched_bus.test_tx     = test_tx_r;
   assign sched_bus.endwait_all = endwait_all_r;
   assign sched_bus.bus_sel     = bus_sel_r;
   assign sched_bus.busy        = busy_r;
   assign sched_bus.scan_done   = scan_done_r;

endmodule

// File: tb/tb_bus_test_scheduler.sv
// tb_bus_test_scheduler: directed self-checking bench for bus_test_scheduler
// (N_BUSES=15, GAP_CYCLES=120, TIMEOUT_CYCLES=64). Timeout scenarios are built
// when SCHED_TIMEOUT_EN is defined; otherwise the unbounded-wait behaviour is checked.
module tb_bus_test_scheduler;
   import mopshub_sched_pkg::*;

   logic clk_40_m = 1'b0;
   logic rst      = 1'b0;

   bus_test_scheduler_if sif ();

   bus_test_scheduler #(
      .N_BUSES        (5'd15),
      .GAP_CYCLES     (120),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_40_m  (clk_40_m),
      .rst       (rst),
      .sched_bus (sif.slave)
   );

   always #5 clk_40_m = ~clk_40_m;

   int checks   = 0;
   int failures = 0;

   // statistics gathered by run_scan
   int rx_bus_q[$];
   int tx_bus_q[$];
   int endw_cnt, scan_cnt, gap_first, tx_len0, done_cycle, done_bus;
   bit finished;

   task automatic step();
      @(posedge clk_40_m);
      #1;
   endtask

   task automatic pulse_start();
      sif.start = 1'b1;
      step();
      sif.start = 1'b0;
   endtask

   // Answers RX/TX tests promptly (TX on silent_tx_bus never answered) until busy drops.
   task automatic run_scan(input int silent_tx_bus, input int max_cycles);
      bit prev_rx = 1'b0;
      bit prev_tx = 1'b0;
      int endw_cycle = -1;
      rx_bus_q.delete();
      tx_bus_q.delete();
      endw_cnt = 0; scan_cnt = 0; gap_first = -1; tx_len0 = 0;
      done_cycle = -1; done_bus = -1; finished = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         if (sif.busy !== 1'b1) begin
            finished = 1'b1;
            break;
         end
         if (sif.test_rx && !prev_rx) rx_bus_q.push_back(int'(sif.bus_sel));
         if (sif.test_tx && !prev_tx) begin
            tx_bus_q.push_back(int'(sif.bus_sel));
            if (gap_first < 0 && endw_cycle >= 0) gap_first = c - endw_cycle;
         end
         if (sif.endwait_all) begin
            endw_cnt++;
            if (endw_cycle < 0) endw_cycle = c;
         end
         if (sif.scan_done) begin
            scan_cnt++;
            done_cycle = c;
            done_bus   = int'(sif.bus_sel);
         end
         if (sif.test_tx && sif.bus_sel == 5'd0) tx_len0++;
         sif.rx_done = sif.test_rx;
         sif.tx_done = sif.test_tx && (int'(sif.bus_sel) != silent_tx_bus);
         prev_rx = sif.test_rx;
         prev_tx = sif.test_tx;
         step();
      end
      sif.rx_done = 1'b0;
      sif.tx_done = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] outs;
      rst = 1'b0;
      step();
      step();
      outs = {sif.osc_trim_en, sif.test_rx, sif.test_tx, sif.endwait_all, sif.bus_sel,
              sif.busy, sif.scan_done, sif.err_timeout, sif.err_bus};
      checks++;
      if (outs !== 17'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", outs, 17'd0);
      end
      rst = 1'b1;
      step();
      checks++;
      if (sif.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy got=%b exp=0", sif.busy);
      end
   endtask

   task automatic test_two_buses();
      sif.bus_mask = 16'h0005;
      sif.end_power_init = 1'b0;
      pulse_start();
      step();
      step();
      checks++;
      if (sif.osc_trim_en !== 1'b1 || sif.busy !== 1'b1 || sif.test_rx !== 1'b0) begin
         failures++;
         $display("FAIL trim_hold osc=%b busy=%b test_rx=%b exp 1 1 0",
                  sif.osc_trim_en, sif.busy, sif.test_rx);
      end
      sif.end_power_init = 1'b1;
      step();
      checks++;
      if (sif.osc_trim_en !== 1'b0) begin
         failures++;
         $display("FAIL trim_exit osc got=%b exp=0", sif.osc_trim_en);
      end
      run_scan(-1, 2000);
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL two_bus_finish timed out exp idle");
      end
      checks++;
      if (rx_bus_q.size() != 2 || rx_bus_q[0] != 0 || rx_bus_q[1] != 2) begin
         failures++;
         $display("FAIL two_bus_rx got size=%0d exp buses 0,2", rx_bus_q.size());
      end
      checks++;
      if (tx_bus_q.size() != 2 || tx_bus_q[0] != 0 || tx_bus_q[1] != 2) begin
         failures++;
         $display("FAIL two_bus_tx got size=%0d exp buses 0,2", tx_bus_q.size());
      end
      checks++;
      if (endw_cnt != 2 || scan_cnt != 1) begin
         failures++;
         $display("FAIL two_bus_pulses endw=%0d scan_done=%0d exp 2 1", endw_cnt, scan_cnt);
      end
      checks++;
      if (gap_first != 121) begin
         failures++;
         $display("FAIL gap_length got=%0d exp=121", gap_first);
      end
      checks++;
      if (sif.bus_sel !== 5'd0 || sif.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL two_bus_end bus_sel=%0d err=%b exp 0 0", sif.bus_sel, sif.err_timeout);
      end
   endtask

   task automatic test_mask_zero();
      sif.bus_mask = 16'h0000;
      pulse_start();
      run_scan(-1, 200);
      checks++;
      if (!finished || rx_bus_q.size() != 0 || tx_bus_q.size() != 0 || endw_cnt != 0) begin
         failures++;
         $display("FAIL mask_zero_tests fin=%b rx=%0d tx=%0d endw=%0d exp 1 0 0 0",
                  finished, rx_bus_q.size(), tx_bus_q.size(), endw_cnt);
      end
      checks++;
      if (scan_cnt != 1 || done_cycle != 17 || done_bus != 15) begin
         failures++;
         $display("FAIL mask_zero_done cnt=%0d cycle=%0d bus=%0d exp 1 17 15",
                  scan_cnt, done_cycle, done_bus);
      end
   endtask

   task automatic test_reset_in_gap();
      logic [16:0] outs;
      bit found = 1'b0;
      sif.bus_mask = 16'h0009;
      pulse_start();
      for (int c = 0; c < 1000; c++) begin
         if (sif.endwait_all && sif.bus_sel == 5'd3) begin
            found = 1'b1;
            break;
         end
         sif.rx_done = sif.test_rx;
         sif.tx_done = sif.test_tx;
         step();
      end
      sif.rx_done = 1'b0;
      sif.tx_done = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (!found || sif.bus_sel !== 5'd3 || sif.busy !== 1'b1 || sif.test_tx !== 1'b0) begin
         failures++;
         $display("FAIL gap_bus3 found=%b bus=%0d busy=%b tx=%b exp 1 3 1 0",
                  found, sif.bus_sel, sif.busy, sif.test_tx);
      end
      rst = 1'b0;
      step();
      outs = {sif.osc_trim_en, sif.test_rx, sif.test_tx, sif.endwait_all, sif.bus_sel,
              sif.busy, sif.scan_done, sif.err_timeout, sif.err_bus};
      checks++;
      if (outs !== 17'd0) begin
         failures++;
         $display("FAIL reset_in_gap got=%h exp=%h", outs, 17'd0);
      end
      rst = 1'b1;
      step();
      pulse_start();
      run_scan(-1, 2000);
      checks++;
      if (!finished || rx_bus_q.size() != 2 || rx_bus_q[0] != 0 || rx_bus_q[1] != 3
          || scan_cnt != 1) begin
         failures++;
         $display("FAIL restart_scan fin=%b rx=%0d scans=%0d exp 1 2 1",
                  finished, rx_bus_q.size(), scan_cnt);
      end
   endtask

   task automatic test_start_while_busy();
      sif.bus_mask = 16'h0002;
      pulse_start();
      for (int c = 0; c < 50 && sif.test_rx !== 1'b1; c++) step();
      sif.start   = 1'b1;
      sif.tx_done = 1'b1;
      step();
      sif.start   = 1'b0;
      sif.tx_done = 1'b0;
      checks++;
      if (sif.test_rx !== 1'b1 || sif.test_tx !== 1'b0 || sif.bus_sel !== 5'd1
          || sif.osc_trim_en !== 1'b0) begin
         failures++;
         $display("FAIL busy_start rx=%b tx=%b bus=%0d osc=%b exp 1 0 1 0",
                  sif.test_rx, sif.test_tx, sif.bus_sel, sif.osc_trim_en);
      end
      run_scan(-1, 1000);
      checks++;
      if (!finished || scan_cnt != 1 || tx_bus_q.size() != 1 || tx_bus_q[0] != 1) begin
         failures++;
         $display("FAIL busy_scan fin=%b scans=%0d tx=%0d exp 1 1 1",
                  finished, scan_cnt, tx_bus_q.size());
      end
      step();
      step();
      checks++;
      if (sif.busy !== 1'b0) begin
         failures++;
         $display("FAIL no_rerun busy got=%b exp=0", sif.busy);
      end
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout_tx();
      sif.bus_mask = 16'h0005;
      pulse_start();
      run_scan(0, 3000);
      checks++;
      if (!finished || tx_len0 != 64) begin
         failures++;
         $display("FAIL tx_timeout_len fin=%b len=%0d exp 1 64", finished, tx_len0);
      end
      checks++;
      if (sif.err_timeout !== 1'b1 || sif.err_bus !== 5'd0) begin
         failures++;
         $display("FAIL tx_timeout_err err=%b bus=%0d exp 1 0", sif.err_timeout, sif.err_bus);
      end
      checks++;
      if (rx_bus_q.size() != 2 || rx_bus_q[1] != 2 || scan_cnt != 1) begin
         failures++;
         $display("FAIL tx_timeout_continue rx=%0d scans=%0d exp 2 1", rx_bus_q.size(), scan_cnt);
      end
      pulse_start();
      checks++;
      if (sif.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got=%b exp=0", sif.err_timeout);
      end
      run_scan(2, 3000);
      checks++;
      if (sif.err_timeout !== 1'b1 || sif.err_bus !== 5'd2) begin
         failures++;
         $display("FAIL tx_timeout_bus2 err=%b bus=%0d exp 1 2", sif.err_timeout, sif.err_bus);
      end
   endtask

   task automatic test_done_on_timeout();
      int hi = 0;
      sif.bus_mask = 16'h0001;
      pulse_start();
      for (int c = 0; c < 200; c++) begin
         if (sif.test_rx) hi++;
         if (hi == 63) begin
            sif.rx_done = 1'b1;
            step();
            sif.rx_done = 1'b0;
            break;
         end
         step();
      end
      checks++;
      if (sif.endwait_all !== 1'b1 || sif.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL done_wins endw=%b err=%b exp 1 0", sif.endwait_all, sif.err_timeout);
      end
      run_scan(-1, 1000);
      checks++;
      if (!finished || sif.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL done_wins_end fin=%b err=%b exp 1 0", finished, sif.err_timeout);
      end
   endtask
`else
   task automatic test_no_timeout();
      sif.bus_mask = 16'h0001;
      pulse_start();
      for (int c = 0; c < 50 && sif.test_rx !== 1'b1; c++) step();
      for (int i = 0; i < 200; i++) step();
      checks++;
      if (sif.test_rx !== 1'b1 || sif.err_timeout !== 1'b0 || sif.endwait_all !== 1'b0) begin
         failures++;
         $display("FAIL rx_waits rx=%b err=%b endw=%b exp 1 0 0",
                  sif.test_rx, sif.err_timeout, sif.endwait_all);
      end
      run_scan(-1, 1000);
      checks++;
      if (!finished || endw_cnt != 1 || scan_cnt != 1 || sif.err_timeout !== 1'b0
          || sif.err_bus !== 5'd0) begin
         failures++;
         $display("FAIL no_timeout_end fin=%b endw=%0d scans=%0d err=%b exp 1 1 1 0",
                  finished, endw_cnt, scan_cnt, sif.err_timeout);
      end
   endtask
`endif

   initial begin
      sif.start          = 1'b0;
      sif.end_power_init = 1'b0;
      sif.bus_mask       = 16'h0000;
      sif.rx_done        = 1'b0;
      sif.tx_done        = 1'b0;
      test_reset();
      test_two_buses();
      test_mask_zero();
      test_reset_in_gap();
      test_start_while_busy();
`ifdef SCHED_TIMEOUT_EN
      test_timeout_tx();
      test_done_on_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
